serial_shift_ctrl: RTL and testbench

//  Sequencer for the lab's D flip-flop shift datapath: accepts a parallel word on a START handshake,

---
 rtl/serial_ctrl_pkg.sv | 18 +
 rtl/shift_reg_core.sv | 30 +++
 rtl/serial_shift_ctrl.sv | 149 ++++++++++++++
 tb/tb_serial_shift_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serial_ctrl_pkg.sv
// Shared constants for the serial shift sequencer: state encoding and default word width.
// Build option SERIAL_PARITY_EN (see serial_shift_ctrl) makes the PAR state reachable.
package serial_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2,
      FIN   = 2'd3
   } state_t;

   function automatic logic parity_step(input logic acc, input logic bit_in);
      return acc ^ bit_in;
   endfunction

endpackage

// File: rtl/shift_reg_core.sv
// WIDTH-bit D-flop chain: synchronous clear, parallel load, right shift with zero fill.
// Only the LSB leaves the block; clear has priority over load, load over shift.
import serial_ctrl_pkg::*;

module shift_reg_core #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] d,
   output logic             lsb
);

   logic [WIDTH-1:0] q;

   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (shift_en) begin
         q <= {1'b0, q[WIDTH-1:1]};
      end
   end

   assign lsb = q[0];

endmodule

// File: rtl/serial_shift_ctrl.sv
// Parallel-to-serial sequencer: captures din on a start handshake and sends it LSB-first on sout.
// Define SERIAL_PARITY_EN to append an even-parity bit after the data bits.
//
//  state | meaning
//  IDLE  | waiting for start; ready high unless the done pulse is showing
//  SHIFT | one data bit per edge onto sout, cnt counts bits sent
//  PAR   | parity bit onto sout (SERIAL_PARITY_EN builds only)
//  FIN   | raise done for one cycle, then back to IDLE
import serial_ctrl_pkg::*;

module serial_shift_ctrl #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             start,
   input  logic             abort,
   output logic             ready,
   output logic             sout,
   output logic             svalid,
   output logic             done
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             sout_nxt, svalid_nxt, done_nxt;
   logic             sreg_clr, sreg_load, sreg_shift;
   logic             sreg_lsb;
   logic             accept;
`ifdef SERIAL_PARITY_EN
   logic             par_acc, par_acc_nxt;
`endif

   // done blocks ready so that a held start always sees one idle cycle between frames
   assign ready  = (state == IDLE) && !done;
   assign accept = start && ready && !abort;

   shift_reg_core #(
      .WIDTH (WIDTH)
   ) u_sreg (
      .clk      (clk),
      .clr      (rst || sreg_clr),
      .load     (sreg_load),
      .shift_en (sreg_shift),
      .d        (din),
      .lsb      (sreg_lsb)
   );

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      sout_nxt    = 1'b0;
      svalid_nxt  = 1'b0;
      done_nxt    = 1'b0;
      sreg_clr    = 1'b0;
      sreg_load   = 1'b0;
      sreg_shift  = 1'b0;
`ifdef SERIAL_PARITY_EN
      par_acc_nxt = par_acc;
`endif

      case (state)
         IDLE: begin
            if (accept) begin
               sreg_load   = 1'b1;
               cnt_nxt     = '0;
               state_nxt   = SHIFT;
`ifdef SERIAL_PARITY_EN
               par_acc_nxt = 1'b0;
`endif
            end
         end
         SHIFT: begin
            sout_nxt    = sreg_lsb;
            svalid_nxt  = 1'b1;
            sreg_shift  = 1'b1;
`ifdef SERIAL_PARITY_EN
            // accumulating the bits as they leave keeps parity tied to the captured word
            par_acc_nxt = parity_step(par_acc, sreg_lsb);
`endif
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
`ifdef SERIAL_PARITY_EN
               state_nxt = PAR;
`else
               state_nxt = FIN;
`endif
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
`ifdef SERIAL_PARITY_EN
         PAR: begin
            sout_nxt   = par_acc;
            svalid_nxt = 1'b1;
            state_nxt  = FIN;
         end
`endif
         FIN: begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (abort && (state != IDLE)) begin
         state_nxt   = IDLE;
         cnt_nxt     = '0;
         sout_nxt    = 1'b0;
         svalid_nxt  = 1'b0;
         done_nxt    = 1'b0;
         sreg_clr    = 1'b1;
         sreg_load   = 1'b0;
         sreg_shift  = 1'b0;
`ifdef SERIAL_PARITY_EN
         par_acc_nxt = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         sout    <= 1'b0;
         svalid  <= 1'b0;
         done    <= 1'b0;
`ifdef SERIAL_PARITY_EN
         par_acc <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         sout    <= sout_nxt;
         svalid  <= svalid_nxt;
         done    <= done_nxt;
`ifdef SERIAL_PARITY_EN
         par_acc <= par_acc_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Self-checking bench for serial_shift_ctrl (WIDTH=8); honours SERIAL_PARITY_EN when defined.
// Expected serial frames come from a word-level model: data bits LSB-first, optional even parity.
module tb_serial_shift_ctrl;

   localparam int W = 8;
`ifdef SERIAL_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif

   logic         clk = 1'b0;
   logic         rst, start, abort;
   logic [W-1:0] din;
   logic         ready, sout, svalid, done;

   int n_assert = 0;
   int n_fail   = 0;

   serial_shift_ctrl #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .din    (din),
      .start  (start),
      .abort  (abort),
      .ready  (ready),
      .sout   (sout),
      .svalid (svalid),
      .done   (done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [NB-1:0] model_frame(input logic [W-1:0] w);
      logic [NB-1:0] f;
      f = '0;
      for (int i = 0; i < W; i++) f[i] = ((int'(w) / (1 << i)) % 2) == 1;
      if (NB > W) f[NB-1] = ($countones(w) % 2) == 1;
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic e_ready, input logic e_sout,
                          input logic e_svalid, input logic e_done);
      check({tag, ".ready"},  ready,  e_ready);
      check({tag, ".sout"},   sout,   e_sout);
      check({tag, ".svalid"}, svalid, e_svalid);
      check({tag, ".done"},   done,   e_done);
   endtask

   // Sends one word from idle; abort_at = bits allowed out before abort (-1: none, NB: abort in FIN).
   task automatic run_frame(input string tag, input logic [W-1:0] w, input int abort_at,
                            input logic poke);
      logic [NB-1:0] exp_f;
      exp_f = model_frame(w);
      din   = w;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk_out({tag, ".accept"}, 1'b0, 1'b0, 1'b0, 1'b0);
      if (poke) begin
         start = 1'b1;
         din   = ~w;
      end
      for (int i = 0; i <= NB; i++) begin
         if (i == abort_at) begin
            abort = 1'b1;
            start = 1'b0;
            tick();
            abort = 1'b0;
            chk_out($sformatf("%s.abort%0d", tag, i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            chk_out($sformatf("%s.postabort%0d", tag, i), 1'b1, 1'b0, 1'b0, 1'b0);
            return;
         end
         if (i == NB) break;
         tick();
         chk_out($sformatf("%s.bit%0d", tag, i), 1'b0, exp_f[i], 1'b1, 1'b0);
      end
      start = 1'b0;
      tick();
      chk_out({tag, ".done"}, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      chk_out({tag, ".idle"}, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [NB-1:0] f1, f2;
      logic [W-1:0]  rw;
      int            ab;

      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      din   = '0;
      tick();
      start = 1'b1;
      din   = 8'h5A;
      tick();
      chk_out("reset", 1'b1, 1'b0, 1'b0, 1'b0);
      start = 1'b0;
      rst   = 1'b0;
      tick();
      chk_out("after_reset", 1'b1, 1'b0, 1'b0, 1'b0);

      run_frame("a5", 8'hA5, -1, 1'b0);
      run_frame("07", 8'h07, -1, 1'b0);
      run_frame("3c_poke", 8'h3C, -1, 1'b1);
      run_frame("f0_abort", 8'hF0, 3, 1'b0);
      run_frame("abort_first", 8'h81, 0, 1'b0);
      run_frame("abort_fin", 8'hC3, NB, 1'b0);

      // abort beats start while idle
      start = 1'b1;
      abort = 1'b1;
      din   = 8'hFF;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk_out("abort_start_idle", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("abort_start_idle2", 1'b1, 1'b0, 1'b0, 1'b0);

      // reset in the middle of a frame
      din   = 8'h5A;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk_out("pre_rst.bit1", 1'b0, 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      chk_out("rst_in_shift", 1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      chk_out("rst_in_shift2", 1'b1, 1'b0, 1'b0, 1'b0);

      // back-to-back frames with start held high
      f1    = model_frame(8'h01);
      f2    = model_frame(8'h80);
      din   = 8'h01;
      start = 1'b1;
      tick();
      din   = 8'h80;
      for (int i = 0; i < NB; i++) begin
         tick();
         chk_out($sformatf("b2b1.bit%0d", i), 1'b0, f1[i], 1'b1, 1'b0);
      end
      tick();
      chk_out("b2b1.done", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      chk_out("b2b.gap", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      start = 1'b0;
      chk_out("b2b2.accept", 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < NB; i++) begin
         tick();
         chk_out($sformatf("b2b2.bit%0d", i), 1'b0, f2[i], 1'b1, 1'b0);
      end
      tick();
      chk_out("b2b2.done", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      chk_out("b2b2.idle", 1'b1, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 24; n++) begin
         rw = W'($urandom);
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB)) : -1;
         run_frame($sformatf("rnd%0d", n), rw, ab, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) begin
            tick();
            chk_out($sformatf("rnd%0d.gap", n), 1'b1, 1'b0, 1'b0, 1'b0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
